// File: rtl/nco_phase_pkg.sv
// rtl/nco_phase_pkg.sv - shared types and constants for the two-channel NCO phase accumulator (dither option: NCO_PHASE_DITHER_EN)
package nco_phase_pkg;

    // Shadow configuration fields are this wide; the top WIDTH parameter defaults to it
    // and must not exceed it.
    localparam int NCO_WIDTH = 16;

    // Number of LFSR bits added into each channel argument when dither is built in.
    localparam int DITHER_BITS = 2;

    // Dither LFSR reset value.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } cfg_state_e;

    typedef struct packed {
        logic                 chan;
        logic [NCO_WIDTH-1:0] freq;
        logic [NCO_WIDTH-1:0] phase;
        logic                 mode;
    } cfg_t;

    // One step of the 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting towards bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/nco_phase_acc_two_ch_ch.sv
// rtl/nco_phase_acc_two_ch_ch.sv - one NCO channel: freq/phase/mode registers, accumulator and argument register
module nco_phase_acc_ch
    import nco_phase_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clkena,
    input  logic                   i_sync,
    input  logic                   i_load,
    input  logic [WIDTH-1:0]       i_freq,
    input  logic [WIDTH-1:0]       i_phase,
    input  logic                   i_mode,
    input  logic [DITHER_BITS-1:0] i_dither,
    output logic [WIDTH-1:0]       o_arg,
    output logic                   o_mode
);

    logic [WIDTH-1:0] r_freq;
    logic [WIDTH-1:0] r_phase;
    logic             r_mode;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_arg;
    logic             r_mode_out;

    // Accumulate and form the argument from the pre-update accumulator; a load only
    // takes effect on the following enabled edge because every use here sees the old registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_freq     <= '0;
            r_phase    <= '0;
            r_mode     <= 1'b0;
            r_acc      <= '0;
            r_arg      <= '0;
            r_mode_out <= 1'b0;
        end else if (i_clkena) begin
            r_acc      <= i_sync ? '0 : r_acc + r_freq;
            r_arg      <= r_acc + r_phase + WIDTH'(i_dither);
            r_mode_out <= r_mode;
            if (i_load) begin
                r_freq  <= i_freq;
                r_phase <= i_phase;
                r_mode  <= i_mode;
            end
        end
    end

    assign o_arg  = r_arg;
    assign o_mode = r_mode_out;

endmodule

// File: rtl/nco_phase_acc_two_ch.sv
// rtl/nco_phase_acc_two_ch.sv - two-channel NCO phase accumulator with config handshake (optional dither: NCO_PHASE_DITHER_EN)
module nco_phase_acc_two_ch
    import nco_phase_pkg::*;
#(
    parameter int WIDTH   = NCO_WIDTH,
    parameter int LATENCY = 4
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             clkena,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_chan,
    input  logic [WIDTH-1:0] cfg_freq,
    input  logic [WIDTH-1:0] cfg_phase,
    input  logic             cfg_mode,
    input  logic             sync,
    output logic [WIDTH-1:0] arg0,
    output logic [WIDTH-1:0] arg1,
    output logic             mode0,
    output logic             mode1,
    output logic             func_valid
);

    cfg_state_e                r_state;
    cfg_state_e                w_next_state;
    logic                      w_apply;
    cfg_t                      r_shadow;
    logic [LATENCY-1:0]        r_fv_sr;
    logic [DITHER_BITS-1:0]    w_dither0;
    logic [DITHER_BITS-1:0]    w_dither1;
    logic                      w_load0;
    logic                      w_load1;

    // Config FSM register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: capture is clock-enable independent, apply waits for an enabled edge.
    always_comb begin
        w_next_state = r_state;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_next_state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (clkena) begin
                    w_apply      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign cfg_ready = (r_state == ST_IDLE);

    // Shadow capture of an accepted request; cleared by reset so a pending update is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (r_state == ST_IDLE && cfg_valid) begin
            r_shadow.chan  <= cfg_chan;
            r_shadow.freq  <= NCO_WIDTH'(cfg_freq);
            r_shadow.phase <= NCO_WIDTH'(cfg_phase);
            r_shadow.mode  <= cfg_mode;
        end
    end

    assign w_load0 = w_apply & ~r_shadow.chan;
    assign w_load1 = w_apply &  r_shadow.chan;

    // Output-valid pipe mirroring the downstream ROM latency in enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fv_sr <= '0;
        end else if (clkena) begin
            r_fv_sr <= LATENCY'({r_fv_sr, 1'b1});
        end
    end

    assign func_valid = r_fv_sr[LATENCY-1];

`ifdef NCO_PHASE_DITHER_EN
    logic [15:0] r_lfsr;

    // Shared dither LFSR; channel 0 takes bits [1:0], channel 1 bits [3:2].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (clkena) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_dither0 = r_lfsr[1:0];
    assign w_dither1 = r_lfsr[3:2];
`else
    assign w_dither0 = '0;
    assign w_dither1 = '0;
`endif

    nco_phase_acc_ch #(.WIDTH(WIDTH)) u_ch0 (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clkena (clkena),
        .i_sync   (sync),
        .i_load   (w_load0),
        .i_freq   (WIDTH'(r_shadow.freq)),
        .i_phase  (WIDTH'(r_shadow.phase)),
        .i_mode   (r_shadow.mode),
        .i_dither (w_dither0),
        .o_arg    (arg0),
        .o_mode   (mode0)
    );

    nco_phase_acc_ch #(.WIDTH(WIDTH)) u_ch1 (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clkena (clkena),
        .i_sync   (sync),
        .i_load   (w_load1),
        .i_freq   (WIDTH'(r_shadow.freq)),
        .i_phase  (WIDTH'(r_shadow.phase)),
        .i_mode   (r_shadow.mode),
        .i_dither (w_dither1),
        .o_arg    (arg1),
        .o_mode   (mode1)
    );

endmodule

// File: tb/tb_nco_phase_acc_two_ch.sv
// tb/tb_nco_phase_acc_two_ch.sv - self-checking bench for nco_phase_acc_two_ch against a behavioural model (NCO_PHASE_DITHER_EN aware)
module tb_nco_phase_acc_two_ch;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clkena;
    logic          cfg_valid;
    logic          cfg_chan;
    logic [W-1:0]  cfg_freq;
    logic [W-1:0]  cfg_phase;
    logic          cfg_mode;
    logic          sync;
    logic          cfg_ready;
    logic [W-1:0]  arg0;
    logic [W-1:0]  arg1;
    logic          mode0;
    logic          mode1;
    logic          func_valid;

    always #5 clk = ~clk;

    nco_phase_acc_two_ch #(.WIDTH(W), .LATENCY(LAT)) dut (
        .reset      (reset),
        .clk        (clk),
        .clkena     (clkena),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_freq   (cfg_freq),
        .cfg_phase  (cfg_phase),
        .cfg_mode   (cfg_mode),
        .sync       (sync),
        .arg0       (arg0),
        .arg1       (arg1),
        .mode0      (mode0),
        .mode1      (mode1),
        .func_valid (func_valid)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference state
    int unsigned m_acc[2];
    int unsigned m_freq[2];
    int unsigned m_phase[2];
    int unsigned m_arg[2];
    int unsigned m_mode[2];
    int unsigned m_mode_out[2];
    bit          m_busy;
    int unsigned m_sh_chan, m_sh_freq, m_sh_phase, m_sh_mode;
    int          m_edges;
    int unsigned m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_acc[n] = 0; m_freq[n] = 0; m_phase[n] = 0;
            m_arg[n] = 0; m_mode[n] = 0; m_mode_out[n] = 0;
        end
        m_busy = 1'b0;
        m_sh_chan = 0; m_sh_freq = 0; m_sh_phase = 0; m_sh_mode = 0;
        m_edges = 0;
        m_lfsr = 32'hACE1;
    endtask

    task automatic model_edge(input bit en, input bit sy);
        bit          was_busy;
        int unsigned dith;
        int unsigned fb;
        was_busy = m_busy;
        if (en) begin
            for (int n = 0; n < 2; n++) begin
`ifdef NCO_PHASE_DITHER_EN
                dith = (m_lfsr >> (2 * n)) % 4;
`else
                dith = 0;
`endif
                m_arg[n]      = (m_acc[n] + m_phase[n] + dith) % 65536;
                m_mode_out[n] = m_mode[n];
                m_acc[n]      = sy ? 0 : (m_acc[n] + m_freq[n]) % 65536;
            end
            if (was_busy) begin
                m_freq[m_sh_chan]  = m_sh_freq;
                m_phase[m_sh_chan] = m_sh_phase;
                m_mode[m_sh_chan]  = m_sh_mode;
                m_busy = 1'b0;
            end
            m_edges++;
            fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) % 2;
            m_lfsr = (m_lfsr / 2) + fb * 32768;
        end
        if (!was_busy && cfg_valid) begin
            m_sh_chan  = cfg_chan;
            m_sh_freq  = cfg_freq;
            m_sh_phase = cfg_phase;
            m_sh_mode  = cfg_mode;
            m_busy     = 1'b1;
        end
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "/arg0"}, 32'(arg0), m_arg[0]);
        chk({ph, "/arg1"}, 32'(arg1), m_arg[1]);
        chk({ph, "/mode0"}, 32'(mode0), m_mode_out[0]);
        chk({ph, "/mode1"}, 32'(mode1), m_mode_out[1]);
        chk({ph, "/cfg_ready"}, 32'(cfg_ready), m_busy ? 0 : 1);
        chk({ph, "/func_valid"}, 32'(func_valid), (m_edges >= LAT) ? 1 : 0);
    endtask

    task automatic tick(input bit en, input bit sy, input string ph);
        clkena = en;
        sync   = sy;
        @(posedge clk);
        model_edge(en, sy);
        #1;
        check_outputs(ph);
    endtask

    task automatic send_cfg(input bit ch, input logic [W-1:0] f, input logic [W-1:0] p, input bit md);
        for (int b = 0; b < 4 && m_busy; b++) tick(1'b1, 1'b0, "drain");
        cfg_chan  = ch;
        cfg_freq  = f;
        cfg_phase = p;
        cfg_mode  = md;
        cfg_valid = 1'b1;
        tick(1'b1, 1'b0, "cfg_accept");
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clkena = 1'b0; cfg_valid = 1'b0; cfg_chan = 1'b0;
        cfg_freq = '0; cfg_phase = '0; cfg_mode = 1'b0; sync = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Channel 0 ramp of +1
        send_cfg(1'b0, 16'h0001, 16'h0000, 1'b0);
        chk("ramp/ready_low", 32'(cfg_ready), 0);
        tick(1'b1, 1'b0, "ramp_apply");
        chk("ramp/ready_back", 32'(cfg_ready), 1);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, "ramp");
            chk("ramp/seq", 32'(arg0), k - 1);
        end

        // Channel 1 quarter-turn steps with offset, cos select
        send_cfg(1'b1, 16'h4000, 16'h1000, 1'b1);
        tick(1'b1, 1'b0, "quarter_apply");
        begin
            logic [15:0] seq1 [5];
            seq1[0] = 16'h1000; seq1[1] = 16'h5000; seq1[2] = 16'h9000;
            seq1[3] = 16'hD000; seq1[4] = 16'h1000;
            for (int k = 0; k < 5; k++) begin
                tick(1'b1, 1'b0, "quarter");
                chk("quarter/arg1", 32'(arg1), 32'(seq1[k]));
                chk("quarter/mode1", 32'(mode1), 1);
            end
        end

        // Accepted config held across disabled cycles; a second request in the window is ignored
        send_cfg(1'b0, 16'h0100, 16'h0020, 1'b1);
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_freq = 16'h7777; cfg_phase = 16'h3333; cfg_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, "hold");
            chk("hold/ready", 32'(cfg_ready), 0);
        end
        cfg_valid = 1'b0;
        tick(1'b1, 1'b0, "hold_apply");
        chk("hold/ready_after", 32'(cfg_ready), 1);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, "post_hold");

        // Sync zeroes the accumulators; argument restarts from the phase offset
        tick(1'b1, 1'b1, "sync_edge");
        tick(1'b1, 1'b0, "sync_p1");
        chk("sync/arg0_restart", 32'(arg0), 32'h0020);
        tick(1'b1, 1'b0, "sync_p2");
        chk("sync/arg0_resume", 32'(arg0), 32'h0120);
        tick(1'b0, 1'b1, "sync_disabled");

        // Randomized enables, syncs and config traffic
        for (int k = 0; k < 300; k++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_chan  = 1'($urandom_range(0, 1));
            cfg_freq  = 16'($urandom);
            cfg_phase = 16'($urandom);
            cfg_mode  = 1'($urandom_range(0, 1));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "random");
        end

        // Reset while a request is pending: discarded, outputs clear at once
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_freq = 16'h5555; cfg_phase = 16'h0AAA; cfg_mode = 1'b1;
        tick(1'b0, 1'b0, "pre_reset");
        cfg_valid = 1'b0;
        chk("midreset/pending", 32'(cfg_ready), 0);
        reset = 1'b1;
        #2;
        model_reset();
        chk("midreset/arg0", 32'(arg0), 0);
        chk("midreset/arg1", 32'(arg1), 0);
        chk("midreset/mode0", 32'(mode0), 0);
        chk("midreset/mode1", 32'(mode1), 0);
        chk("midreset/ready", 32'(cfg_ready), 1);
        chk("midreset/fv", 32'(func_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 1'b0, "latency");
            chk("latency/fv", 32'(func_valid), (k >= LAT) ? 1 : 0);
        end
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_phase_acc_two_ch.md
NCO_PHASE_ACC_TWO_CH -- requirements
Module: nco_phase_acc_two_ch

Interface
REQ-001 Parameter WIDTH, default 16, phase/argument width; matches the downstream sin/cos ROM WIDTH.
REQ-002 Parameter LATENCY, default 4, downstream ROM latency in clkena-qualified cycles.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 clkena  input  1  clock enable; all state except cfg handshake capture advances only when 1.
REQ-006 cfg_valid  input  1  configuration request.
REQ-007 cfg_ready  output  1  configuration accept.
REQ-008 cfg_chan  input  1  target channel (0/1).
REQ-009 cfg_freq  input  WIDTH  frequency (phase increment) word.
REQ-010 cfg_phase  input  WIDTH  phase offset word.
REQ-011 cfg_mode  input  1  function select for channel (0 sin, 1 cos).
REQ-012 sync  input  1  zero both accumulators.
REQ-013 arg0, arg1  output  WIDTH  each  phase arguments to the ROM.
REQ-014 mode0, mode1  output  1  each  function select to the ROM.
REQ-015 func_valid  output  1  high when ROM outputs reflect valid arguments.

Function
REQ-016 Per channel n, on clk edge with clkena=1: acc_n <= acc_n + freq_n, modulo 2^WIDTH (wrap, no saturation).
REQ-017 Same edge: arg_n <= acc_n + phase_n (pre-update acc_n, modulo 2^WIDTH); mode_n output registered from mode_n state.
REQ-018 clkena=0: acc, arg, mode, func_valid, dither state hold.
REQ-019 Config FSM states IDLE, PENDING; cfg_ready = 1 only in IDLE.
REQ-020 IDLE and cfg_valid=1: capture cfg_chan/freq/phase/mode into shadow regardless of clkena; go PENDING.
REQ-021 PENDING and clkena=1: load shadow into freq/phase/mode of selected channel; go IDLE; cfg_ready returns 1 next cycle.
REQ-022 cfg_valid in PENDING ignored; requester holds until cfg_ready=1.
REQ-023 Applied freq used from the next clkena edge onward; applied phase/mode appear on arg/mode at the next clkena edge.
REQ-024 sync=1 with clkena=1: acc0, acc1 <= 0 (no add); arg_n <= acc_n + phase_n as normal; coincident config apply still occurs.
REQ-025 sync with clkena=0 ignored.
REQ-026 func_valid: LATENCY-bit shift register, shifts in 1 on each clkena edge; func_valid = its MSB.

Reset
REQ-027 reset=1 asynchronously clears: acc, freq, phase, arg = 0; mode = 0; shadow = 0; FSM = IDLE (cfg_ready=1); func_valid shift register = 0.
REQ-028 reset during PENDING discards shadow; no channel update occurs.

Configuration
REQ-029 Macro NCO_PHASE_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances each clkena edge; its 2 LSBs added (zero-extended) into arg_n, modulo 2^WIDTH; one LFSR shared, channel 1 uses bits [3:2].
REQ-030 Macro undefined: no LFSR; arg_n exactly per REQ-017.

Structure
REQ-031 Package nco_phase_pkg: cfg_t struct (chan, freq, phase, mode), fsm state enum, DITHER_BITS=2, LFSR_SEED constant.
REQ-032 Sub-module nco_phase_acc_ch (one channel: freq/phase/mode regs, accumulator, arg register), instantiated twice.

Verification (dither disabled unless stated)
REQ-033 Reset release; cfg chan0 freq=1, phase=0 -> cfg_ready low one clkena cycle; thereafter arg0 samples 0,1,2,3,... consecutive +1.
REQ-034 cfg chan1 freq=16'h4000, phase=16'h1000, mode=1 -> arg1 cycles 1000,5000,9000,D000,1000 (wrap), mode1=1, arg0 unaffected.
REQ-035 cfg accepted, clkena=0 for 3 cycles -> arg/acc hold, cfg_ready stays 0, update lands on first clkena=1 edge; second cfg_valid in that window not accepted.
REQ-036 Running freq=16'h0100, assert sync one clkena cycle -> arg0 following sample = phase0 + 16'h0000 two edges later, then resumes +0100.
REQ-037 Reset release with clkena=1 -> func_valid rises after exactly LATENCY=4 edges; reset asserted mid-run -> all outputs zero immediately, cfg_ready=1.
REQ-038 NCO_PHASE_DITHER_EN defined, freq=0, phase=0 -> arg0 values in {0..3} follow LFSR from seed 16'hACE1, matching reference model.
